// File: rtl/regfile_dump_uart_tx_pkg.sv
// Shared types and constants for the register-file UART dump block.
// DUMP_SYNC_HEADER_EN (when defined) adds a 0xA5 sync frame before register 0.
package regfile_dump_pkg;

    localparam int       WORD_W         = 32;
    localparam int       BYTES_PER_WORD = WORD_W / 8;
    localparam int       FRAME_BITS     = 10;
    localparam bit [7:0] SYNC_BYTE      = 8'hA5;

    // Dump sequencer states. HDR spans the whole sync-byte frame.
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        START,
        DATA,
        STOP
    } dump_state_t;

    // Serializer phases.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_START,
        PH_DATA,
        PH_STOP
    } tx_phase_t;

endpackage

// File: rtl/regfile_dump_uart_tx_if.sv
// Bundle between the dump block, the register file debug port and the UART pin.
// Handshake: dump_req is a level sampled only while the block is idle; busy
// rises on the accepting edge and falls together with the one-cycle done pulse.
interface regfile_dump_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              dump_req;
    logic [ADDR_W-1:0] raddr_dbg;
    logic [DATA_W-1:0] rdata_dbg;
    logic              tx;
    logic              busy;
    logic              done;

    // Dump block side.
    modport slave (
        input  dump_req,
        input  rdata_dbg,
        output raddr_dbg,
        output tx,
        output busy,
        output done
    );

    // Requester / register file side.
    modport master (
        output dump_req,
        output rdata_dbg,
        input  raddr_dbg,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/regfile_dump_uart_tx_uart_tx_byte.sv
// 8N1 byte serializer, LSB first. A tx_start during the last stop-bit cycle
// chains the next frame with no idle gap.
module uart_tx_byte
    import regfile_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_o,
    input  logic       rst_n,
    input  logic       tx_start_i,
    input  logic [7:0] tx_byte_i,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       start_end_o,
    output logic       data_end_o,
    output tx_phase_t  phase_o
);
    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_phase_t     phase_q, phase_d;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          bit_end;
    logic          accept;

    assign bit_end = (baud_q == BAUD_LAST);
    assign accept  = tx_start_i && ((phase_q == PH_IDLE) || (phase_q == PH_STOP && bit_end));
    assign phase_o = phase_q;

    // Phase register.
    always_ff @(posedge clk_o or negedge rst_n) begin
        if (!rst_n) phase_q <= PH_IDLE;
        else        phase_q <= phase_d;
    end

    // Next phase: advance at the end of each bit period.
    always_comb begin
        phase_d = phase_q;
        if (accept) begin
            phase_d = PH_START;
        end else begin
            case (phase_q)
                PH_START: if (bit_end) phase_d = PH_DATA;
                PH_DATA:  if (bit_end && bit_q == 3'd7) phase_d = PH_STOP;
                PH_STOP:  if (bit_end) phase_d = PH_IDLE;
                default:  phase_d = phase_q;
            endcase
        end
    end

    // Line level and status strobes decoded from the current phase.
    always_comb begin
        tx_o        = 1'b1;
        tx_busy_o   = (phase_q != PH_IDLE);
        tx_done_o   = 1'b0;
        start_end_o = 1'b0;
        data_end_o  = 1'b0;
        case (phase_q)
            PH_START: begin
                tx_o        = 1'b0;
                start_end_o = bit_end;
            end
            PH_DATA: begin
                tx_o       = shift_q[0];
                data_end_o = bit_end && (bit_q == 3'd7);
            end
            PH_STOP: tx_done_o = bit_end;
            default: tx_o = 1'b1;
        endcase
    end

    // Baud counter, bit counter and shift register.
    always_ff @(posedge clk_o or negedge rst_n) begin
        if (!rst_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else if (accept) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= tx_byte_i;
        end else if (phase_q != PH_IDLE) begin
            baud_q <= bit_end ? '0 : baud_q + 1'b1;
            if (phase_q == PH_DATA && bit_end) begin
                shift_q <= {1'b0, shift_q[7:1]};
                bit_q   <= bit_q + 3'd1;
            end
        end
    end
endmodule

// File: rtl/regfile_dump_uart_tx.sv
// Register-file dump over UART: walks x0..x(NUM_REGS-1), snapshots each word
// in a one-cycle LOAD and sends it little-endian as four 8N1 frames.
// DUMP_SYNC_HEADER_EN: prepend one 0xA5 frame, started on the accepting edge.
module regfile_dump_uart_tx
    import regfile_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32
) (
    input  logic          clk_o,
    input  logic          rst_n,
    regfile_dump_if.slave bus,
    output dump_state_t   state_o
);
    localparam int                BPW       = DATA_W / 8;
    localparam int                BW        = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BW-1:0]     LAST_BYTE = BW'(BPW - 1);
    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] reg_idx_q;
    logic [BW-1:0]     byte_idx_q;
    logic [BW-1:0]     next_byte_idx;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] load_word;
    logic              busy_q, done_q;

    logic       ser_start, ser_tx, ser_busy, ser_done, ser_start_end, ser_data_end;
    logic [7:0] ser_byte;
    tx_phase_t  ser_phase;

    // x0 always reads as zero, whatever the array holds.
    assign load_word     = (reg_idx_q == '0) ? '0 : bus.rdata_dbg;
    assign next_byte_idx = byte_idx_q + 1'b1;

    assign bus.raddr_dbg = reg_idx_q;
    assign bus.tx        = ser_tx;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign state_o       = state_q;

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clk_o       (clk_o),
        .rst_n       (rst_n),
        .tx_start_i  (ser_start),
        .tx_byte_i   (ser_byte),
        .tx_o        (ser_tx),
        .tx_busy_o   (ser_busy),
        .tx_done_o   (ser_done),
        .start_end_o (ser_start_end),
        .data_end_o  (ser_data_end),
        .phase_o     (ser_phase)
    );

    // State register.
    always_ff @(posedge clk_o or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: byte/register sequencing, bit timing comes from the serializer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.dump_req && !ser_busy) begin
`ifdef DUMP_SYNC_HEADER_EN
                    state_d = HDR;
`else
                    state_d = LOAD;
`endif
                end
            end
            HDR:   if (ser_done) state_d = LOAD;
            LOAD:  state_d = START;
            START: if (ser_start_end) state_d = DATA;
            DATA:  if (ser_data_end) state_d = STOP;
            STOP: begin
                if (ser_done) begin
                    if (byte_idx_q != LAST_BYTE)     state_d = START;
                    else if (reg_idx_q != LAST_REG) state_d = LOAD;
                    else                            state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serializer requests: first byte straight from the read port in LOAD,
    // following bytes chained in the last stop-bit cycle.
    always_comb begin
        ser_start = 1'b0;
        ser_byte  = 8'h00;
        case (state_q)
`ifdef DUMP_SYNC_HEADER_EN
            IDLE: begin
                ser_start = bus.dump_req && !ser_busy;
                ser_byte  = SYNC_BYTE;
            end
`endif
            LOAD: begin
                ser_start = 1'b1;
                ser_byte  = load_word[7:0];
            end
            STOP: begin
                ser_start = ser_done && (byte_idx_q != LAST_BYTE);
                ser_byte  = word_q[{next_byte_idx, 3'b000} +: 8];
            end
            default: ser_start = 1'b0;
        endcase
    end

    // Word snapshot, indices and busy/done flags.
    always_ff @(posedge clk_o or negedge rst_n) begin
        if (!rst_n) begin
            reg_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (state_d != IDLE) begin
                        reg_idx_q  <= '0;
                        byte_idx_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    word_q     <= load_word;
                    byte_idx_q <= '0;
                end
                STOP: begin
                    if (ser_done) begin
                        if (byte_idx_q != LAST_BYTE) begin
                            byte_idx_q <= next_byte_idx;
                        end else if (reg_idx_q != LAST_REG) begin
                            reg_idx_q <= reg_idx_q + 1'b1;
                        end else begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: done_q <= 1'b0;
            endcase
        end
    end
endmodule
